reg2reg_rr_arb: RTL and testbench
=================================

REG2REG_RR_ARB -- requirements
Module: reg2reg_rr_arb

Interface
REQ-001 Parameter HOLD_MAX, default 4, max consecutive accepted transfers per grant while the other side requests; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 req0  input  1  requester 0 request, level.
REQ-005 in0  input  2  requester 0 data.
REQ-006 req1  input  1  requester 1 request, level.
REQ-007 in1  input  2  requester 1 data.
REQ-008 gnt0  output  1  grant to requester 0, registered.
REQ-009 gnt1  output  1  grant to requester 1, registered.
REQ-010 out_vld  output  1  pipeline output valid.
REQ-011 out_data  output  2  pipeline output data.
REQ-012 out_src  output  1  source of out_data (0 = requester 0, 1 = requester 1).

Function
REQ-013 gnt0 and gnt1 SHALL be one-hot or zero; never both high.
REQ-014 Accepted transfer: cycle with gntX=1 and reqX=1; inX sampled at that cycle's closing edge.
REQ-015 FSM states IDLE, G0, G1; gnt0=1 only in G0, gnt1=1 only in G1.
REQ-016 IDLE: no request -> stay; only reqX -> GX; both -> requester not named by last-served pointer lp.
REQ-017 GX with reqX=0 -> G(other) if other requests, else IDLE; no transfer in that cycle.
REQ-018 GX with reqX=1: hold counter cnt increments per accepted transfer; cnt resets to 0 on every state change.
REQ-019 GX, accepted transfer making cnt reach HOLD_MAX, other requesting -> G(other) next cycle.
REQ-020 GX, cnt reaches HOLD_MAX, other not requesting -> stay GX, cnt reloads to 0.
REQ-021 lp SHALL update to X on each entry into GX.
REQ-022 Datapath: two register stages; latency 2 edges from the accepting edge to out_vld/out_data/out_src.
REQ-023 Stage-1 valid = accepted transfer; non-accepted cycles SHALL propagate out_vld=0 (bubble) and hold out_data/out_src unchanged.
REQ-024 Back-to-back transfers (including a switch G0->G1) SHALL give out_vld=1 on consecutive cycles with no bubble beyond REQ-017 cycles.
REQ-025 cnt width 4 bits; no wrap beyond HOLD_MAX.

Reset
REQ-026 rst=0 at a rising edge: state IDLE, cnt=0, lp=1, gnt0=gnt1=0, both pipeline stages valid=0, data=2'b00, src=0.
REQ-027 Reset mid-burst SHALL discard in-flight pipeline contents; out_vld=0 at the edge after reset sampled.
REQ-028 First grant after reset with both requesting SHALL go to requester 0.

Structure
REQ-029 Shared package reg2reg_arb_pkg SHALL hold state encodings (IDLE=2'd0, G0=2'd1, G1=2'd2) and counter width constant.
REQ-030 Datapath SHALL be sub-module reg2reg_pipe (2-stage valid/data/src register chain with synchronous active-low reset); FSM, counter, pointer in top.

Verification
REQ-031 Reset, req0=req1=1 held -> gnt0 after first edge; HOLD_MAX=4 transfers; then gnt1 for 4; alternating.
REQ-032 req0 only, in0=01,11,10,00 over 4 accepted cycles -> out_data 01,11,10,00 with out_src=0, out_vld=1, 2 edges after each acceptance.
REQ-033 req1 held alone 6 cycles, HOLD_MAX=4 -> gnt1 stays high throughout, cnt reloads, 6 consecutive valid outputs with out_src=1.
REQ-034 In G0, req0 drops while req1=1 -> one gnt0 cycle with no transfer, then gnt1; out_vld shows exactly one bubble.
REQ-035 rst=0 asserted one cycle after an acceptance -> gnt0=gnt1=0 and out_vld=0 next edge; that transfer never appears.
REQ-036 Every cycle: assert !(gnt0 && gnt1) and out_vld only 2 edges after an accepted transfer.

Source files
------------

// File: rtl/reg2reg_arb_pkg.sv
// reg2reg_arb_pkg: shared arbiter state encoding, counter width and pipeline beat type
package reg2reg_arb_pkg;
    localparam int CNT_W  = 4;
    localparam int DATA_W = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;
    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] data;
        logic              src;
    } beat_t;
endpackage

// File: rtl/reg2reg_pipe.sv
// reg2reg_pipe: 2-stage valid/data/src register chain
// Ports: clk; rst (sync, active-low); acc/data/src = accepted beat in;
// out_vld/out_data/out_src = beat two edges later. Data/src hold through bubbles.
import reg2reg_arb_pkg::*;
module reg2reg_pipe (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc,
    input  logic [DATA_W-1:0] data,
    input  logic              src,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src
);
    beat_t s1, s2;
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= acc ? '{vld: 1'b1, data: data, src: src} : '{vld: 1'b0, data: s1.data, src: s1.src};
            s2 <= s1.vld ? s1 : '{vld: 1'b0, data: s2.data, src: s2.src};
        end
    end
    assign out_vld  = s2.vld;
    assign out_data = s2.data;
    assign out_src  = s2.src;
endmodule

// File: rtl/reg2reg_rr_arb.sv
// reg2reg_rr_arb: two-requester round-robin arbiter with hold limit feeding a 2-stage pipeline
// Ports: clk; rst (sync, active-low); req0/in0, req1/in1 = requests and data;
// gnt0/gnt1 = registered grants; out_vld/out_data/out_src = pipelined accepted data.
import reg2reg_arb_pkg::*;
module reg2reg_rr_arb #(
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] in0,
    input  logic              req1,
    input  logic [DATA_W-1:0] in1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src
);
    state_t           state, nxt;
    logic [CNT_W-1:0] cnt, cnt_inc, cnt_nxt;
    logic             lp, acc0, acc1, hold_done;
    assign acc0      = gnt0 && req0;
    assign acc1      = gnt1 && req1;
    assign cnt_inc   = cnt + 1'b1;
    assign hold_done = cnt_inc == CNT_W'(HOLD_MAX);
    // lp names the last-served side; with both requesting from IDLE the other side wins
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = (req0 && (!req1 || lp)) ? G0 : req1 ? G1 : IDLE;
            G0:      nxt = !req0 ? (req1 ? G1 : IDLE) : (hold_done && req1) ? G1 : G0;
            G1:      nxt = !req1 ? (req0 ? G0 : IDLE) : (hold_done && req0) ? G0 : G1;
            default: nxt = IDLE;
        endcase
        cnt_nxt = (nxt != state) ? '0 : (acc0 || acc1) ? (hold_done ? '0 : cnt_inc) : cnt;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            lp    <= 1'b1;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            lp    <= (nxt != state && nxt != IDLE) ? (nxt == G1) : lp;
            gnt0  <= nxt == G0;
            gnt1  <= nxt == G1;
        end
    end
    reg2reg_pipe u_pipe (
        .clk      (clk),
        .rst      (rst),
        .acc      (acc0 || acc1),
        .data     (acc1 ? in1 : in0),
        .src      (acc1),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_src  (out_src)
    );
endmodule

// File: tb/tb_reg2reg_rr_arb.sv
// tb_reg2reg_rr_arb: scoreboard bench with a behavioural arbiter model and randomized traffic
module tb_reg2reg_rr_arb;
    localparam int HOLD = 4;
    logic       clk = 1'b0, rst = 1'b0, req0 = 1'b0, req1 = 1'b0;
    logic [1:0] in0 = 2'b00, in1 = 2'b00;
    logic       gnt0, gnt1, out_vld, out_src;
    logic [1:0] out_data;
    int         checks = 0, fails = 0, cyc = 0;
    typedef struct {logic [1:0] data; logic src; int due;} exp_t;
    exp_t       q[$];
    int         owner = 0, streak = 0, last = 1;

    reg2reg_rr_arb #(.HOLD_MAX(HOLD)) dut (
        .clk(clk), .rst(rst), .req0(req0), .in0(in0), .req1(req1), .in1(in1),
        .gnt0(gnt0), .gnt1(gnt1), .out_vld(out_vld), .out_data(out_data), .out_src(out_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // owner: 0 nobody, 1 requester 0, 2 requester 1; last: last-served requester index
    task automatic step(input logic r, input logic a, input logic [1:0] da, input logic b, input logic [1:0] db);
        int nxt;
        logic mine, other;
        @(negedge clk);
        rst = r; req0 = a; in0 = da; req1 = b; in1 = db;
        #1;
        check("gnt0", int'(gnt0), int'(owner == 1));
        check("gnt1", int'(gnt1), int'(owner == 2));
        if (!r) begin
            q.delete();
            owner = 0; streak = 0; last = 1;
        end else begin
            if (owner == 1 && a) q.push_back('{da, 1'b0, cyc + 2});
            if (owner == 2 && b) q.push_back('{db, 1'b1, cyc + 2});
            nxt = owner;
            if (owner == 0) begin
                if (a && b) nxt = (last == 1) ? 1 : 2;
                else if (a || b) nxt = a ? 1 : 2;
            end else begin
                mine  = (owner == 1) ? a : b;
                other = (owner == 1) ? b : a;
                if (!mine) nxt = other ? 3 - owner : 0;
                else begin
                    streak++;
                    if (streak == HOLD) begin
                        streak = 0;
                        if (other) nxt = 3 - owner;
                    end
                end
            end
            if (nxt != owner) begin
                streak = 0;
                if (nxt != 0) last = nxt - 1;
            end
            owner = nxt;
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT shows a valid beat
    initial begin
        logic       rs, ls;
        logic [1:0] ld;
        exp_t       e;
        ld = 2'b00; ls = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            rs = rst;
            #1;
            checks++;
            if (gnt0 && gnt1) begin
                fails++;
                $display("FAIL onehot cyc=%0d: gnt0=%0b gnt1=%0b", cyc, gnt0, gnt1);
            end
            if (!rs) begin
                check("rst_vld", int'(out_vld), 0);
                check("rst_data", int'(out_data), 0);
                check("rst_src", int'(out_src), 0);
                ld = 2'b00; ls = 1'b0;
            end else if (out_vld) begin
                if (q.size() == 0) check("unexpected_vld", 1, 0);
                else begin
                    e = q.pop_front();
                    check("data", int'(out_data), int'(e.data));
                    check("src", int'(out_src), int'(e.src));
                    check("latency_due", cyc, e.due);
                end
                ld = out_data; ls = out_src;
            end else begin
                if (q.size() != 0 && q[0].due <= cyc) check("missing_vld", 0, 1);
                check("hold_data", int'(out_data), int'(ld));
                check("hold_src", int'(out_src), int'(ls));
            end
        end
    end

    initial begin
        logic [1:0] pat[4];
        pat = '{2'b01, 2'b11, 2'b10, 2'b00};
        repeat (2) step(0, 0, 0, 0, 0);
        repeat (20) step(1, 1, 2'($urandom), 1, 2'($urandom));
        repeat (2) step(1, 0, 0, 0, 0);
        step(1, 1, 2'b00, 0, 0);
        foreach (pat[i]) step(1, 1, pat[i], 0, 0);
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 1, 2'(i));
        step(1, 1, 0, 0, 0);
        step(1, 1, 2'b10, 1, 2'b01);
        step(1, 1, 2'b11, 1, 2'b01);
        step(1, 0, 0, 1, 2'b10);
        repeat (3) step(1, 0, 0, 1, 2'($urandom));
        step(1, 0, 0, 0, 0);
        step(1, 1, 2'b00, 0, 0);
        step(1, 1, 2'b11, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), 2'($urandom),
                 ($urandom_range(0, 2) != 0), 2'($urandom));
        repeat (4) step(1, 0, 0, 0, 0);
        check("drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
